// File: rtl/debug_pkg.sv
// debug_pkg
// Shared definitions for the debug display block: segment glyph lookup,
// the blank glyph, button roles and the status LED layout.
//   SEG_BLANK  : all segments off (active-low)
//   BTN_*      : bit positions of the four push buttons on btn[3:0]
//   led_t      : packed status LED word {valid_seen, hold, 2'b0, sel}
//   hex_to_seg : nibble -> active-low {g,f,e,d,c,b,a}
package debug_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int NUM_BTNS  = 4;
    localparam int BTN_NEXT  = 0;  // advance channel select
    localparam int BTN_HOLD  = 1;  // toggle freeze of capture
    localparam int BTN_CLEAR = 2;  // zero capture and valid_seen
    localparam int BTN_RSVD  = 3;  // reserved, no function

    typedef struct packed {
        logic       valid_seen;
        logic       hold;
        logic [1:0] zero;
        logic [3:0] sel;
    } led_t;

    // Active-low segment pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Two-flop synchroniser followed by a counting debouncer for one raw button.
// The debounced level follows the synchronised input only after the two have
// disagreed for DEBOUNCE_CYCLES consecutive clocks; any agreement restarts
// the count, so bounces shorter than that are swallowed.
//   clk, rst_n : system clock, async active-low reset
//   btn_raw    : asynchronous button input
//   press      : one-clock pulse when the debounced level rises 0->1
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic             level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn_raw};
            press <= 1'b0;
            if (sync[1] != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync[1];
                    press <= sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/debug_display.sv
// debug_display
// Captures one of NUM_CHANNELS 32-bit debug words and shows it on a
// multiplexed NUM_DIGITS hex display, with buttons for channel select,
// hold and clear, plus status LEDs.
//   clk, rst_n : system clock, async active-low reset
//   ch_data    : NUM_CHANNELS x 32-bit words, channel k at [32k+31:32k]
//   ch_valid   : per-channel one-clock strobes
//   btn        : raw buttons {reserved, clear, hold, next}
//   an         : digit anodes, active-low one-hot (registered)
//   seg        : segments {g,f,e,d,c,b,a}, active-low (registered)
//   led        : {valid_seen, hold, 2'b0, sel}
// Build option: define DEBUG_DISPLAY_BLANK_EN to blank leading zero digits.
module debug_display
    import debug_pkg::*;
#(
    parameter int NUM_DIGITS      = 8,
    parameter int NUM_CHANNELS    = 4,
    parameter int SCAN_DIV        = 12500,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CHANNELS*32-1:0] ch_data,
    input  logic [NUM_CHANNELS-1:0]   ch_valid,
    input  logic [3:0]                btn,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic [7:0]                led
);

    localparam int SEL_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SCAN_W = $clog2(SCAN_DIV);

    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_CHANNELS - 1);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    // ---------------------------------------------------------------
    // Buttons
    // ---------------------------------------------------------------
    logic [NUM_BTNS-1:0] btn_press;

    genvar b;
    generate
        for (b = 0; b < NUM_BTNS; b++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_btn (
                .clk    (clk),
                .rst_n  (rst_n),
                .btn_raw(btn[b]),
                .press  (btn_press[b])
            );
        end
    endgenerate

    logic press_rsvd_unused;
    assign press_rsvd_unused = btn_press[BTN_RSVD];

    // ---------------------------------------------------------------
    // Control state
    // ---------------------------------------------------------------
    logic [SEL_W-1:0] sel;
    logic             hold;
    logic             valid_seen;
    logic [31:0]      capture;
    logic [31:0]      sel_data;
    logic             sel_strobe;

    assign sel_data   = ch_data[32*sel +: 32];
    assign sel_strobe = ch_valid[sel];

    // Capture priority: clear beats a channel change, and either one
    // discards a same-clock strobe. The select itself still advances on a
    // next-press even when clear lands in the same clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= '0;
            hold       <= 1'b0;
            valid_seen <= 1'b0;
            capture    <= '0;
        end else begin
            if (btn_press[BTN_NEXT])
                sel <= (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
            if (btn_press[BTN_HOLD])
                hold <= ~hold;

            if (btn_press[BTN_CLEAR] || btn_press[BTN_NEXT]) begin
                capture    <= '0;
                valid_seen <= 1'b0;
            end else if (sel_strobe && !hold) begin
                capture    <= sel_data;
                valid_seen <= 1'b1;
            end
        end
    end

    led_t led_s;
    always_comb begin
        led_s            = '0;
        led_s.valid_seen = valid_seen;
        led_s.hold       = hold;
        led_s.sel        = 4'(sel);
    end
    assign led = led_s;

    // ---------------------------------------------------------------
    // Scan timing
    // ---------------------------------------------------------------
    // The first terminal count after reset only arms the scanner, so the
    // first slot shown is digit 0. The output registers load one clock
    // after each terminal count (scan_tick), i.e. one clock after the
    // digit index moves.
    logic [SCAN_W-1:0] scan_cnt;
    logic [DIG_W-1:0]  digit;
    logic              armed;
    logic              scan_tick;
    logic              scan_tc;

    assign scan_tc = (scan_cnt == SCAN_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            digit     <= '0;
            armed     <= 1'b0;
            scan_tick <= 1'b0;
        end else begin
            scan_tick <= scan_tc;
            if (scan_tc) begin
                scan_cnt <= '0;
                armed    <= 1'b1;
                if (armed)
                    digit <= (digit == DIG_LAST) ? '0 : digit + DIG_W'(1);
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------
    // Digit decode and output registers
    // ---------------------------------------------------------------
    logic [3:0] nibble;
    logic       digit_blank;

    assign nibble = capture[4*digit +: 4];

`ifdef DEBUG_DISPLAY_BLANK_EN
    // Only nibbles that are actually on the display count toward
    // "leading"; anything above the top digit is ignored.
    localparam logic [31:0] DISP_MASK = (NUM_DIGITS >= 8) ? 32'hFFFF_FFFF :
                                        32'((64'd1 << (4*NUM_DIGITS)) - 64'd1);
    always_comb begin
        digit_blank = 1'b0;
        if (digit != '0)
            digit_blank = (((capture & DISP_MASK) >> (4*digit)) == 32'd0);
    end
`else
    assign digit_blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= SEG_BLANK;
        end else if (scan_tick) begin
            if (digit_blank) begin
                an  <= '1;
                seg <= SEG_BLANK;
            end else begin
                an  <= ~(NUM_DIGITS'(1) << digit);
                seg <= hex_to_seg(nibble);
            end
        end
    end

endmodule
